// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell run LSB-first over WIDTH cycles.
// Ports: clk, reset_n, start/sub/a/b in; busy, done, y, cout, ovf out.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Single full-adder cell on the current LSBs
  assign fa_s  = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_co = (a_q[0] & b_q[0]) |
                 (c_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract as a + ~b + 1: invert b, seed carry with 1
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          y_d     = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        y_d = {fa_s, y_q[WIDTH-1:1]};
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        c_d = fa_co;
        if (cnt_q == LAST) begin
          // c_q is the carry into the MSB here
          cout_d  = fa_co;
          ovf_d   = c_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Directed cases, handshake corners, mid-op reset and a random sweep.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .y       (y),
    .cout    (cout),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, {ovf, cout, y}
  function automatic logic [9:0] model(input bit s,
                                       input logic [7:0] x,
                                       input logic [7:0] z);
    int ux, uz, sx, sz, sr, ur;
    bit c, o;
    ux = int'(x);
    uz = int'(z);
    sx = (ux > 127) ? ux - 256 : ux;
    sz = (uz > 127) ? uz - 256 : uz;
    if (s) begin
      ur = (ux - uz + 256) % 256;
      c  = (ux >= uz);
      sr = sx - sz;
    end else begin
      ur = (ux + uz) % 256;
      c  = (ux + uz) > 255;
      sr = sx + sz;
    end
    o = (sr > 127) || (sr < -128);
    return {o, c, ur[7:0]};
  endfunction

  // Drive a start for one edge, then scramble operands
  task automatic launch(input bit s, input logic [7:0] x,
                        input logic [7:0] z);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = z;
    @(posedge clk);
    #1;
    start = 1'b0;
    sub   = 1'($urandom);
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Called #1 after the start edge; returns edges until done
  task automatic wait_done(output int lat, output int bcnt,
                           output bit to);
    lat  = 0;
    bcnt = 0;
    to   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, y, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b y=%h cout=%b ovf=%b want all 0",
               busy, done, y, cout, ovf);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    bit          vs [5];
    logic [7:0]  va [5];
    logic [7:0]  vb [5];
    logic [9:0]  exp [5];
    int lat, bc;
    bit to;
    vs = '{0, 0, 0, 1, 1};
    va = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h80};
    vb = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    exp = '{10'b00_0001_0000, 10'b10_1000_0000, 10'b01_0000_0000,
            10'b00_1111_1110, 10'b11_0111_1111};
    for (int i = 0; i < 5; i++) begin
      launch(vs[i], va[i], vb[i]);
      wait_done(lat, bc, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: no done within 40 edges", i);
      end
      checks++;
      if ({ovf, cout, y} !== exp[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got ovf=%b cout=%b y=%h want %b",
                 i, ovf, cout, y, exp[i]);
      end
      checks++;
      if (lat != W || bc != W) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy=%0d want %0d %0d",
                 i, lat, bc, W, W);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_hold;
    logic [7:0] yh;
    int lat, bc;
    bit to;
    launch(1'b0, 8'h3C, 8'h21);
    wait_done(lat, bc, to);
    yh = y;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (y !== 8'h5D || yh !== 8'h5D || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got y=%h (at done %h) done=%b busy=%b want 5d 0 0",
               y, yh, done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit to;
    launch(1'b0, 8'h0F, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc, to);
    checks++;
    if (to || y !== 8'h10 || lat != W - 3) begin
      errors++;
      $display("FAIL ignore_start: got y=%h lat=%0d to=%b want 10 %0d 0",
               y, lat, to, W - 3);
    end
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'h80;
    b     = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || y !== 8'h00) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b y=%h want 1 0 00",
               busy, done, y);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || {ovf, cout, y} !== 10'b11_0111_1111 || lat != W) begin
      errors++;
      $display("FAIL b2b_result: got ovf=%b cout=%b y=%h lat=%0d want 1 1 7f %0d",
               ovf, cout, y, lat, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    bit to;
    launch(1'b1, 8'h80, 8'h01);
    wait_done(lat, bc, to);
    @(posedge clk);
    #1;
    launch(1'b0, 8'h55, 8'h22);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, y, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b y=%h cout=%b ovf=%b want all 0",
               busy, done, y, cout, ovf);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    launch(1'b0, 8'h7F, 8'h01);
    wait_done(lat, bc, to);
    checks++;
    if (to || {ovf, cout, y} !== 10'b10_1000_0000) begin
      errors++;
      $display("FAIL reset_mid_after: got ovf=%b cout=%b y=%h want 1 0 80",
               ovf, cout, y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    bit         s;
    logic [7:0] x, z;
    logic [9:0] e;
    int lat, bc, gap;
    bit to;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      x = 8'($urandom);
      z = 8'($urandom);
      e = model(s, x, z);
      launch(s, x, z);
      wait_done(lat, bc, to);
      checks++;
      if (to || {ovf, cout, y} !== e || lat != W) begin
        errors++;
        $display("FAIL random[%0d]: %s %h,%h got ovf=%b cout=%b y=%h lat=%0d want %b",
                 i, s ? "sub" : "add", x, z, ovf, cout, y, lat, e);
      end
      // Mix back-to-back starts with idle gaps
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
